// File: rtl/bernoulli_sampler_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | Module   : bernoulli_sampler_pkg                                    |
// | Brief    : Shared types/constants for the Bernoulli unit sampler    |
// | Revision : 1.0                                                      |
// +---------------------------------------------------------------------+
package bernoulli_sampler_pkg;

   localparam int PROB_W = 8;

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      FULL    = 1'b1
   } state_e;

   function automatic int ones_cnt_w(input int num_units);
      return $clog2(num_units + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bernoulli_sampler_if.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | Module   : bernoulli_sampler_if                                     |
// | Brief    : Probability-in / packed-sample-out handshake bundle      |
// | Revision : 1.0                                                      |
// +---------------------------------------------------------------------+
interface bernoulli_sampler_if
   import bernoulli_sampler_pkg::*;
#(
   parameter int NUM_UNITS = 8,
   parameter int PROB_W    = bernoulli_sampler_pkg::PROB_W
);
   localparam int CNT_W = ones_cnt_w(NUM_UNITS);

   logic [PROB_W-1:0]    randIn;
   logic [PROB_W-1:0]    probIn;
   logic                 probValid;
   logic                 probLast;
   logic                 probReady;
   logic [NUM_UNITS-1:0] sampleOut;
   logic [CNT_W-1:0]     onesCount;
   logic                 sampleLast;
   logic                 sampleValid;
   logic                 sampleReady;

   modport master (
      output randIn, probIn, probValid, probLast, sampleReady,
      input  probReady, sampleOut, onesCount, sampleLast, sampleValid
   );

   modport slave (
      input  randIn, probIn, probValid, probLast, sampleReady,
      output probReady, sampleOut, onesCount, sampleLast, sampleValid
   );

endinterface
`default_nettype wire

// File: rtl/bernoulli_sampler_bit.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | Module   : bernoulli_bit                                            |
// | Brief    : One Bernoulli draw: 1 when the random word < probability |
// | Revision : 1.0                                                      |
// +---------------------------------------------------------------------+
module bernoulli_bit #(
   parameter int PROB_W = 8
) (
   input  wire logic [PROB_W-1:0] randIn,
   input  wire logic [PROB_W-1:0] probIn,
   output logic                   sampleBit
);

   assign sampleBit = (randIn < probIn);

endmodule
`default_nettype wire

// File: rtl/bernoulli_sampler.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | Module   : bernoulli_sampler                                        |
// | Brief    : Samples units and packs them into words with a popcount  |
// | Revision : 1.0                                                      |
// +---------------------------------------------------------------------+
module bernoulli_sampler
   import bernoulli_sampler_pkg::*;
#(
   parameter int NUM_UNITS = 8,
   parameter int PROB_W    = bernoulli_sampler_pkg::PROB_W
) (
   input  wire logic          clk,
   input  wire logic          reset,
   bernoulli_sampler_if.slave bus
);

   localparam int CNT_W = ones_cnt_w(NUM_UNITS);
   localparam int IDX_W = $clog2(NUM_UNITS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_UNITS - 1);

   state_e               state_q, state_d;
   logic [NUM_UNITS-1:0] word_q,  word_d;
   logic [IDX_W-1:0]     idx_q,   idx_d;
   logic [CNT_W-1:0]     ones_q,  ones_d;
   logic                 last_q,  last_d;
   logic                 sample_bit;

   bernoulli_bit #(
      .PROB_W (PROB_W)
   ) u_bit (
      .randIn    (bus.randIn),
      .probIn    (bus.probIn),
      .sampleBit (sample_bit)
   );

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      idx_d   = idx_q;
      ones_d  = ones_q;
      last_d  = last_q;
      case (state_q)
         COLLECT: begin
            if (bus.probValid) begin
               word_d[idx_q] = sample_bit;
               ones_d        = ones_q + CNT_W'(sample_bit);
               // Index parks on the closing unit so it never wraps inside a word.
               if (idx_q == LAST_IDX || bus.probLast) begin
                  state_d = FULL;
                  last_d  = bus.probLast;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         FULL: begin
            if (bus.sampleReady) begin
               state_d = COLLECT;
               word_d  = '0;
               idx_d   = '0;
               ones_d  = '0;
               last_d  = 1'b0;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= COLLECT;
         word_q  <= '0;
         idx_q   <= '0;
         ones_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
         ones_q  <= ones_d;
         last_q  <= last_d;
      end
   end

   assign bus.probReady   = (state_q == COLLECT);
   assign bus.sampleValid = (state_q == FULL);
   assign bus.sampleOut   = word_q;
   assign bus.onesCount   = ones_q;
   assign bus.sampleLast  = last_q;

endmodule
`default_nettype wire

// File: tb/tb_bernoulli_sampler.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | Module   : tb_bernoulli_sampler                                     |
// | Brief    : Directed + random bench with a transaction-level model   |
// | Revision : 1.0                                                      |
// +---------------------------------------------------------------------+
module tb_bernoulli_sampler;

   localparam int N = 8;
   localparam int W = 8;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   bernoulli_sampler_if #(.NUM_UNITS(N), .PROB_W(W)) bus ();

   bernoulli_sampler #(.NUM_UNITS(N), .PROB_W(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a word is either being filled (count of units so far) or pending delivery.
   logic [N-1:0] m_word;
   int           m_n;
   bit           m_pend;
   bit           m_last;
   int           m_words_out;

   function automatic int popcnt(input logic [N-1:0] v);
      int c = 0;
      for (int i = 0; i < N; i++) c += int'(v[i]);
      return c;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_word = '0; m_n = 0; m_pend = 0; m_last = 0;
      end else if (!m_pend) begin
         if (bus.probValid) begin
            m_word[m_n] = (int'(bus.randIn) < int'(bus.probIn));
            m_n++;
            if (m_n == N || bus.probLast) begin
               m_pend = 1;
               m_last = bus.probLast;
            end
         end
      end else if (bus.sampleReady) begin
         m_words_out++;
         m_word = '0; m_n = 0; m_pend = 0; m_last = 0;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("probReady", 32'(bus.probReady), 32'(!m_pend));
         chk("sampleValid", 32'(bus.sampleValid), 32'(m_pend));
         if (m_pend) begin
            chk("sampleOut", 32'(bus.sampleOut), 32'(m_word));
            chk("onesCount", 32'(bus.onesCount), 32'(popcnt(m_word)));
            chk("sampleLast", 32'(bus.sampleLast), 32'(m_last));
         end
      end
   end

   task automatic send(input logic [W-1:0] p, input logic [W-1:0] r, input logic last);
      int waited = 0;
      while (!bus.probReady && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.probReady) chk("send_ready_timeout", 32'(bus.probReady), 32'd1);
      bus.probValid = 1'b1;
      bus.probIn    = p;
      bus.randIn    = r;
      bus.probLast  = last;
      @(negedge clk);
      bus.probValid = 1'b0;
      bus.probLast  = 1'b0;
      bus.randIn    = W'($urandom);
   endtask

   task automatic drain();
      bus.sampleReady = 1'b1;
      @(negedge clk);
      bus.sampleReady = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_out"}, 32'(bus.sampleOut), 32'd0);
      chk({tag, "_ones"}, 32'(bus.onesCount), 32'd0);
      chk({tag, "_last"}, 32'(bus.sampleLast), 32'd0);
      chk({tag, "_valid"}, 32'(bus.sampleValid), 32'd0);
      chk({tag, "_ready"}, 32'(bus.probReady), 32'd1);
   endtask

   logic [N-1:0] held;
   int           words_before;

   initial begin
      checks = 0; failures = 0; m_words_out = 0;
      reset = 1'b1;
      bus.probValid = 1'b0; bus.probLast = 1'b0; bus.probIn = '0;
      bus.randIn = '0; bus.sampleReady = 1'b0;
      @(negedge clk);
      chk_zero("reset");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Full word of ones, no probLast
      for (int i = 0; i < N; i++) send(8'd128, W'(i), 1'b0);
      chk("w1_valid", 32'(bus.sampleValid), 32'd1);
      chk("w1_out", 32'(bus.sampleOut), 32'hFF);
      chk("w1_ones", 32'(bus.onesCount), 32'd8);
      chk("w1_last", 32'(bus.sampleLast), 32'd0);
      drain();

      // Probability edges
      for (int i = 0; i < N; i++) send(8'h00, 8'h00, 1'b0);
      chk("p0_out", 32'(bus.sampleOut), 32'h00);
      chk("p0_ones", 32'(bus.onesCount), 32'd0);
      drain();
      for (int i = 0; i < N; i++) send(8'hFF, 8'hFF, 1'b0);
      chk("pff_out", 32'(bus.sampleOut), 32'h00);
      drain();

      // Early probLast
      send(8'd200, 8'd10, 1'b0);
      send(8'd200, 8'd10, 1'b0);
      send(8'd200, 8'd10, 1'b1);
      chk("early_out", 32'(bus.sampleOut), 32'h07);
      chk("early_ones", 32'(bus.onesCount), 32'd3);
      chk("early_last", 32'(bus.sampleLast), 32'd1);
      drain();

      // Back-pressure: pending word holds, inputs ignored
      for (int i = 0; i < N; i++) send(W'($urandom), W'($urandom), 1'b0);
      held = bus.sampleOut;
      bus.probValid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.probIn = W'($urandom); bus.randIn = W'($urandom);
         @(negedge clk);
         chk("bp_ready", 32'(bus.probReady), 32'd0);
         chk("bp_hold", 32'(bus.sampleOut), 32'(held));
      end
      bus.probValid = 1'b0;
      drain();
      chk("bp_release_ready", 32'(bus.probReady), 32'd1);

      // Reset mid-word
      for (int i = 0; i < 4; i++) send(8'hFF, 8'h00, 1'b0);
      reset = 1'b1;
      #1;
      chk_zero("midreset");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      send(8'hFF, 8'h00, 1'b0);
      for (int i = 1; i < N; i++) send(8'h00, 8'h00, 1'b0);
      chk("fresh_out", 32'(bus.sampleOut), 32'h01);
      chk("fresh_ones", 32'(bus.onesCount), 32'd1);
      drain();

      // probLast on the full-word boundary: exactly one word
      words_before = m_words_out;
      for (int i = 0; i < N; i++) send(W'($urandom), W'($urandom), i == N - 1);
      chk("bnd_last", 32'(bus.sampleLast), 32'd1);
      chk("bnd_ones", 32'(bus.onesCount), 32'($countones(bus.sampleOut)));
      drain();
      repeat (3) @(negedge clk);
      chk("bnd_no_extra", 32'(bus.sampleValid), 32'd0);
      chk("bnd_one_word", 32'(m_words_out - words_before), 32'd1);

      // Random traffic against the model
      for (int c = 0; c < 400; c++) begin
         bus.probValid   = ($urandom_range(0, 3) != 0);
         bus.probIn      = W'($urandom);
         bus.randIn      = W'($urandom);
         bus.probLast    = ($urandom_range(0, 9) == 0);
         bus.sampleReady = ($urandom_range(0, 2) != 0);
         @(negedge clk);
      end
      bus.probValid = 1'b0;
      bus.probLast  = 1'b0;
      drain();
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
